// File: rtl/spimemory_param_if.sv
// SPI pin bundle between a board-level master and the spimemory_param slave.
// miso_pin is kept off this bundle: it is a tri-state output and stays a plain
// module port so the high-impedance driver sits directly on the boundary.
interface spimemory_param_if;
    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;

    modport master (output sclk_pin, output cs_pin, output mosi_pin);
    modport slave  (input  sclk_pin, input  cs_pin, input  mosi_pin);
endinterface

// File: rtl/spimemory_param.sv
// spimemory_param: SPI mode-0 slave in front of a DEPTH x DATA_W register file.
// Frame: (ADDR_W+1)-bit command {address, rw} MSB-first, then DATA_W-bit words.
// Optional feature macro: SPIMEM_BURST_EN (multi-word burst with wrapping
// address). Without it exactly one word is transferred per chip-select frame.
module spimemory_param #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 2**ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    spimemory_param_if.slave   spi,
    output wire                miso_pin
);
    localparam int CMD_BITS = ADDR_W + 1;
    localparam int MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        IDLE, CMD, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, DONE
    } state_t;

    // Out-of-range command addresses alias onto the array modulo DEPTH.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'(a) % 32'(DEPTH);
        return ADDR_W'(w);
    endfunction

    // Reset: asynchronous assertion, synchronous release.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    // Two-flop reset release synchronizer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Pin synchronizers and edge detection.
    // cs resets to "low" so a cs_pin held low across reset cannot fake a
    // cs_fall; a new frame needs cs to go high and then fall again.
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    // Shift pins through SYNC_STAGES flops and keep the previous synced level.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk_pin};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi.cs_pin};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi_pin};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign cs_rise   =  cs_s   & ~cs_prev_q;
    assign cs_fall   = ~cs_s   &  cs_prev_q;

    // Storage: not cleared by reset.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;

    // Protocol state.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [ADDR_W:0]   cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              miso_q, miso_d;
    logic              miso_en_q, miso_en_d;

`ifdef SPIMEM_BURST_EN
    logic [ADDR_W-1:0] addr_next;
    assign addr_next = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
`endif

    // Next-state and datapath decode; cs_rise overrides everything, including
    // an sclk edge seen in the same cycle.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        sreg_d    = sreg_q;
        miso_d    = miso_q;
        miso_en_d = miso_en_q;
        mem_we    = 1'b0;
        if (cs_rise) begin
            state_d   = IDLE;
            bitcnt_d  = '0;
            miso_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d  = CMD;
                        bitcnt_d = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_d = CMD_BITS'({cmd_q, mosi_s});
                        if (bitcnt_q == CNT_W'(CMD_BITS - 1)) begin
                            bitcnt_d = '0;
                            addr_d   = wrap_addr(cmd_d[ADDR_W:1]);
                            state_d  = cmd_d[0] ? RD_LOAD : WR_SHIFT;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                RD_LOAD: begin
                    sreg_d   = mem[addr_q];
                    bitcnt_d = '0;
                    state_d  = RD_SHIFT;
                end
                RD_SHIFT: begin
                    // Each falling edge presents the next bit, MSB first.
                    if (sclk_fall) begin
                        miso_d    = sreg_q[DATA_W-1];
                        miso_en_d = 1'b1;
                        sreg_d    = DATA_W'({sreg_q, 1'b0});
                    end
                    // The master samples on rising edges; the DATA_W-th ends the word.
                    if (sclk_rise) begin
                        if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
                            bitcnt_d = '0;
`ifdef SPIMEM_BURST_EN
                            addr_d  = addr_next;
                            state_d = RD_LOAD;
`else
                            state_d   = DONE;
                            miso_en_d = 1'b0;
`endif
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                WR_SHIFT: begin
                    if (sclk_rise) begin
                        sreg_d = DATA_W'({sreg_q, mosi_s});
                        if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
                            bitcnt_d = '0;
                            state_d  = WR_COMMIT;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                WR_COMMIT: begin
                    mem_we = 1'b1;
`ifdef SPIMEM_BURST_EN
                    addr_d  = addr_next;
                    state_d = WR_SHIFT;
`else
                    state_d = DONE;
`endif
                end
                DONE: begin
                    miso_en_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Protocol registers.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            sreg_q    <= '0;
            miso_q    <= 1'b0;
            miso_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            sreg_q    <= sreg_d;
            miso_q    <= miso_d;
            miso_en_q <= miso_en_d;
        end
    end

    // Word commit into the register file.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= sreg_q;
    end

    assign miso_pin = miso_en_q ? miso_q : 1'bz;

endmodule

// File: tb/tb_spimemory_param.sv
// Directed bench for spimemory_param: a default instance (7-bit address,
// 8-bit data) and a 4/16/12 instance share sclk/mosi with separate chip
// selects. miso nets are pulled up, so a released (z) miso reads as 1.
module tb_spimemory_param;
    localparam int H = 8;   // sclk half period in clk cycles
`ifdef SPIMEM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs0 = 1'b1;
    logic cs1 = 1'b1;
    wire  miso0, miso1;
    pullup pu0 (miso0);
    pullup pu1 (miso1);

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spimemory_param_if if0 ();
    spimemory_param_if if1 ();
    assign if0.sclk_pin = sclk;
    assign if0.mosi_pin = mosi;
    assign if0.cs_pin   = cs0;
    assign if1.sclk_pin = sclk;
    assign if1.mosi_pin = mosi;
    assign if1.cs_pin   = cs1;

    spimemory_param u_dut0 (.clk(clk), .reset_n(reset_n), .spi(if0), .miso_pin(miso0));
    spimemory_param #(.ADDR_W(4), .DATA_W(16), .DEPTH(12)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .spi(if1), .miso_pin(miso1));

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_set(input int sel, input logic v);
        if (sel == 0) cs0 = v; else cs1 = v;
    endtask

    // Mode-0 shift of nb bits; miso sampled just before each rising edge.
    task automatic xfer(input int sel, input logic [31:0] tx, input int nb, output logic [31:0] rx);
        rx = '0;
        for (int i = nb - 1; i >= 0; i--) begin
            mosi = tx[i];
            wait_clk(H);
            rx[i] = (sel == 0) ? miso0 : miso1;
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
    endtask

    task automatic write_frame(input int sel, input int aw, input logic [31:0] addr,
                               input int dw, input logic [31:0] data, input int nw,
                               output logic [31:0] rxd);
        logic [31:0] rxc;
        cs_set(sel, 1'b0);
        wait_clk(H);
        xfer(sel, addr << 1, aw + 1, rxc);
        xfer(sel, data, dw * nw, rxd);
        wait_clk(H);
        cs_set(sel, 1'b1);
        wait_clk(H);
    endtask

    // mid: miso shortly after the last falling edge, cs still low.
    // post: miso after cs has gone high.
    task automatic read_frame(input int sel, input int aw, input logic [31:0] addr,
                              input int dw, input int nw, output logic [31:0] rxd,
                              output logic [31:0] rxc, output logic mid, output logic post);
        cs_set(sel, 1'b0);
        wait_clk(H);
        xfer(sel, (addr << 1) | 32'd1, aw + 1, rxc);
        xfer(sel, 32'd0, dw * nw, rxd);
        wait_clk(6);
        mid = (sel == 0) ? miso0 : miso1;
        wait_clk(H);
        cs_set(sel, 1'b1);
        wait_clk(H);
        post = (sel == 0) ? miso0 : miso1;
    endtask

    task automatic test_reset();
        wait_clk(5);
        n_checks++;
        if (miso0 !== 1'b1) begin n_fail++; $display("FAIL reset_miso0: got %b expected 1 (z)", miso0); end
        n_checks++;
        if (miso1 !== 1'b1) begin n_fail++; $display("FAIL reset_miso1: got %b expected 1 (z)", miso1); end
        reset_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic test_write_read();
        logic [31:0] d, c;
        logic mid, post;
        write_frame(0, 7, 32'h60, 8, 32'h30, 1, d);
        n_checks++;
        if (d[7:0] !== 8'hFF) begin n_fail++; $display("FAIL wr_miso_z: got %h expected ff", d[7:0]); end
        read_frame(0, 7, 32'h60, 8, 1, d, c, mid, post);
        n_checks++;
        if (d[7:0] !== 8'h30) begin n_fail++; $display("FAIL rd_0x60: got %h expected 30", d[7:0]); end
        n_checks++;
        if (c[7:0] !== 8'hFF) begin n_fail++; $display("FAIL rd_cmd_miso_z: got %h expected ff", c[7:0]); end
        n_checks++;
        if (mid !== (BURST ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL rd_after_word: got %b expected %b", mid, BURST ? 1'b0 : 1'b1); end
        n_checks++;
        if (post !== 1'b1) begin n_fail++; $display("FAIL rd_after_cs: got %b expected 1 (z)", post); end
    endtask

    task automatic test_abort();
        logic [31:0] d, c;
        logic mid, post;
        write_frame(0, 7, 32'h05, 8, 32'hA7, 1, d);
        cs0 = 1'b0;
        wait_clk(H);
        xfer(0, 32'h0A, 8, c);
        xfer(0, 32'h1F, 5, d);
        wait_clk(H);
        cs0 = 1'b1;
        wait_clk(H);
        n_checks++;
        if (miso0 !== 1'b1) begin n_fail++; $display("FAIL abort_miso_z: got %b expected 1 (z)", miso0); end
        read_frame(0, 7, 32'h05, 8, 1, d, c, mid, post);
        n_checks++;
        if (d[7:0] !== 8'hA7) begin n_fail++; $display("FAIL abort_mem: got %h expected a7", d[7:0]); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d, c;
        logic mid, post;
        cs0 = 1'b0;
        wait_clk(H);
        xfer(0, 32'h0B, 8, c);
        xfer(0, 32'h0, 3, d);
        n_checks++;
        if (d[2:0] !== 3'b101) begin n_fail++; $display("FAIL rst_rd_bits: got %b expected 101", d[2:0]); end
        wait_clk(5);
        n_checks++;
        if (miso0 !== 1'b0) begin n_fail++; $display("FAIL rst_rd_bit4: got %b expected 0", miso0); end
        reset_n = 1'b0;
        wait_clk(1);
        n_checks++;
        if (miso0 !== 1'b1) begin n_fail++; $display("FAIL rst_miso_z: got %b expected 1 (z)", miso0); end
        cs0 = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(6);
        read_frame(0, 7, 32'h05, 8, 1, d, c, mid, post);
        n_checks++;
        if (d[7:0] !== 8'hA7) begin n_fail++; $display("FAIL rst_reread: got %h expected a7", d[7:0]); end
    endtask

    task automatic test_burst_wrap();
        logic [31:0] d, c, exp;
        logic mid, post;
        write_frame(0, 7, 32'h00, 8, 32'h5A, 1, d);
        write_frame(0, 7, 32'h01, 8, 32'hC3, 1, d);
        write_frame(0, 7, 32'h7F, 8, 32'h112233, 3, d);
        n_checks++;
        if (d[23:0] !== 24'hFFFFFF) begin n_fail++; $display("FAIL burst_wr_miso_z: got %h expected ffffff", d[23:0]); end
        read_frame(0, 7, 32'h7F, 8, 1, d, c, mid, post);
        n_checks++;
        if (d[7:0] !== 8'h11) begin n_fail++; $display("FAIL burst_mem7f: got %h expected 11", d[7:0]); end
        read_frame(0, 7, 32'h00, 8, 1, d, c, mid, post);
        exp = BURST ? 32'h22 : 32'h5A;
        n_checks++;
        if (d[7:0] !== exp[7:0]) begin n_fail++; $display("FAIL burst_mem00: got %h expected %h", d[7:0], exp[7:0]); end
        read_frame(0, 7, 32'h01, 8, 1, d, c, mid, post);
        exp = BURST ? 32'h33 : 32'hC3;
        n_checks++;
        if (d[7:0] !== exp[7:0]) begin n_fail++; $display("FAIL burst_mem01: got %h expected %h", d[7:0], exp[7:0]); end
        read_frame(0, 7, 32'h7F, 8, 3, d, c, mid, post);
        exp = BURST ? 32'h112233 : 32'h11FFFF;
        n_checks++;
        if (d[23:0] !== exp[23:0]) begin n_fail++; $display("FAIL burst_rd: got %h expected %h", d[23:0], exp[23:0]); end
    endtask

    task automatic test_param();
        logic [31:0] d, c, exp;
        logic mid, post;
        write_frame(1, 4, 32'd0, 16, 32'h0F0F, 1, d);
        write_frame(1, 4, 32'd11, 16, 32'hBEEF1234, 2, d);
        read_frame(1, 4, 32'd11, 16, 1, d, c, mid, post);
        n_checks++;
        if (d[15:0] !== 16'hBEEF) begin n_fail++; $display("FAIL p_mem11: got %h expected beef", d[15:0]); end
        read_frame(1, 4, 32'd0, 16, 1, d, c, mid, post);
        exp = BURST ? 32'h1234 : 32'h0F0F;
        n_checks++;
        if (d[15:0] !== exp[15:0]) begin n_fail++; $display("FAIL p_mem0: got %h expected %h", d[15:0], exp[15:0]); end
        read_frame(1, 4, 32'd11, 16, 2, d, c, mid, post);
        exp = BURST ? 32'hBEEF1234 : 32'hBEEFFFFF;
        n_checks++;
        if (d !== exp) begin n_fail++; $display("FAIL p_burst_rd: got %h expected %h", d, exp); end
        write_frame(1, 4, 32'd13, 16, 32'hA55A, 1, d);
        read_frame(1, 4, 32'd1, 16, 1, d, c, mid, post);
        n_checks++;
        if (d[15:0] !== 16'hA55A) begin n_fail++; $display("FAIL p_alias_1: got %h expected a55a", d[15:0]); end
        read_frame(1, 4, 32'd13, 16, 1, d, c, mid, post);
        n_checks++;
        if (d[15:0] !== 16'hA55A) begin n_fail++; $display("FAIL p_alias_13: got %h expected a55a", d[15:0]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_abort();
        test_reset_mid_read();
        test_burst_wrap();
        test_param();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spimemory_param.md
# spimemory_param

Parametrised SPI-slave memory: a next-generation `spimemory` with configurable address width, data width and depth. It adds input synchronisation, explicit abort handling and an optional multi-word burst mode. It sits between the board-level SPI pins and an on-chip register-file RAM. Frames are MSB-first: an (ADDR_W+1)-bit command of address followed by an R/W bit, then DATA_W-bit data words.

## Interface
- `ADDR_W`, 7, address bits in the command frame.
- `DATA_W`, 8, bits per data word and memory word width.
- `DEPTH`, 2**ADDR_W, memory words; addresses ≥ DEPTH alias modulo DEPTH.
- `SYNC_STAGES`, 2, flop stages on `sclk_pin`, `cs_pin`, `mosi_pin` (minimum 2).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sclk_pin`  in  1  SPI clock, mode 0 (idle low, sample on rising edge, drive on falling edge).
- `cs_pin`  in  1  chip select, active low.
- `mosi_pin`  in  1  serial data in.
- `miso_pin`  out  1  serial data out, tri-stated (`z`) when not driving.

## Operation
- Pin inputs pass through SYNC_STAGES flops, then edge detectors.
  - The edge detectors produce one-`clk` pulses: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- States: IDLE, CMD, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, DONE.
- IDLE:
  - `cs_fall` → CMD; bit counter cleared.
- CMD:
  - Each `sclk_rise` shifts synced mosi into the command register.
  - After ADDR_W+1 bits, bits [ADDR_W:1] are latched as address and bit 0 as R/W.
  - R/W = 1 → RD_LOAD; R/W = 0 → WR_SHIFT.
- RD_LOAD (1 `clk`):
  - Read mem[address]; load the DATA_W output shift register; go to RD_SHIFT.
- RD_SHIFT:
  - `miso_pin` is enabled at the first `sclk_fall` after the command and drives the MSB.
  - Each subsequent `sclk_fall` shifts out the next bit.
  - The word ends at the DATA_W-th `sclk_rise`.
- WR_SHIFT:
  - Each `sclk_rise` shifts mosi into the input register.
  - After DATA_W bits → WR_COMMIT.
- WR_COMMIT (1 `clk`):
  - mem[address] ← input register.
  - Then → DONE, or → WR_SHIFT in burst mode.
- DONE:
  - `miso_pin` = z; all `sclk` activity ignored until `cs_rise`.
- `cs_rise` from any state → IDLE, `miso_pin` = z, bit counter cleared.
- Abort:
  - A partially shifted write word is discarded and memory is unchanged.
  - A committed word stays written.
- A `cs_rise` pulse and an `sclk` pulse in the same `clk` cycle: `cs_rise` wins and the `sclk` pulse is dropped.
- Address arithmetic: ADDR_W-bit unsigned, wraps DEPTH-1 → 0. DEPTH is not required to be a power of 2; the increment wraps at DEPTH.
- Memory is not cleared by reset.

## Timing
- Reset (async assert, sync deassert internally):
  - state = IDLE, `miso_pin` = z, counters, shift registers and address = 0.
- Pin-to-pulse latency: SYNC_STAGES+1 `clk` cycles.
- Required `sclk` high and low times: each ≥ SYNC_STAGES+4 `clk` periods.
- Required `cs` setup to first `sclk` rise: ≥ SYNC_STAGES+2 `clk` periods.
- Read data valid on `miso_pin` within SYNC_STAGES+2 `clk` of the pin-level `sclk` fall.
  - This data is held until the next such point.
- Write commit occurs SYNC_STAGES+2 `clk` after the pin-level last data rising edge.
- `reset_n` low mid-frame:
  - Immediate IDLE and `miso_pin` = z.
  - Any write not yet committed is lost.
  - The next frame requires a fresh `cs_fall`.

## Configuration
- `SPIMEM_BURST_EN` defined:
  - After each word (read end or WR_COMMIT), with `cs` still low, address increments (wrapping) and the block continues.
  - Read: RD_LOAD → RD_SHIFT for the next word, with no gap bit between words.
  - Write: WR_SHIFT accepts the next word.
- `SPIMEM_BURST_EN` undefined:
  - Exactly one word per frame; then DONE until `cs` deasserts.
  - The address register never increments.

## Test plan
- Write then read, defaults:
  - Write frame `cmd 1100000_0`, data `00110000`.
  - Then read frame `cmd 1100000_1`.
  - Required: mem[0x60] = 0x30; `miso_pin` shifts `0,0,1,1,0,0,0,0` on successive falling edges; z before and after.
- Abort:
  - Write cmd to address 0x05, 5 data bits of 0xFF, then `cs` high.
  - Required: mem[0x05] keeps its prior value (pre-load 0xA7); state IDLE; `miso_pin` = z.
- Reset mid-read:
  - Assert `reset_n` = 0 after 3 read bits.
  - Required: `miso_pin` = z within 1 `clk`; state IDLE; the next read of the same address returns the full word 0xA7.
- Burst wrap (macro on):
  - Write at address 0x7F with 3 words 0x11, 0x22, 0x33.
  - Required: mem[0x7F]=0x11, mem[0x00]=0x22, mem[0x01]=0x33; burst read from 0x7F returns 0x11, 0x22, 0x33 back-to-back.
- Macro off:
  - Same 3-word write.
  - Required: only mem[0x7F] = 0x11; mem[0x00] and mem[0x01] unchanged; `miso_pin` stays z.
- Parametric:
  - ADDR_W=4, DATA_W=16, DEPTH=12.
  - Write 0xBEEF at address 11, then burst write 0x1234.
  - Required: mem[11]=0xBEEF; the burst word wraps to mem[0]=0x1234 (macro on); read-back matches 16-bit MSB-first.
